// File: rtl/fuzzy_defuzz_pkg.sv
// fuzzy_defuzz_pkg: shared state type, default sizes, derived widths and term-center generator
package fuzzy_defuzz_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DIVIDE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int NUM_TERMS_DEF = 8;
    localparam int MU_W_DEF      = 10;
    localparam int OUT_W_DEF     = 10;

    // Width of the membership sum: NUM_TERMS values of mu_w bits never overflow this
    function automatic int sum_mu_width(input int mu_w, input int n);
        return mu_w + $clog2(n);
    endfunction

    // Width of the weighted sum: adds the center width on top of the membership sum
    function automatic int sum_w_width(input int mu_w, input int out_w, input int n);
        return mu_w + out_w + $clog2(n);
    endfunction

    // Evenly spaced term centers spanning the full output range, rounded to nearest
    function automatic int center(input int k, input int n, input int w);
        return (2 * k * ((1 << w) - 1) + (n - 1)) / (2 * (n - 1));
    endfunction

endpackage

// File: rtl/fuzzy_restoring_divider.sv
// fuzzy_restoring_divider: fixed-latency restoring divider, one quotient bit per cycle MSB first
module fuzzy_restoring_divider #(
    parameter int DW = 23,
    parameter int VW = 13,
    parameter int QW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          done,
    output logic          div_zero,
    output logic [QW-1:0] quotient
);

    localparam int W  = DW + QW;
    localparam int CW = $clog2(QW + 1);

    logic [W-1:0]  rem;
    logic [W-1:0]  dsh;
    logic [QW-1:0] q;
    logic [CW-1:0] cnt;
    logic          fit;

    assign fit      = rem >= dsh;
    assign done     = cnt == CW'(1);
    // The final bit is folded in combinationally so the quotient is complete in the last step
    assign quotient = {q[QW-2:0], fit};

    // Load operands on start, then subtract-or-keep one shifted divisor per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rem      <= '0;
            dsh      <= '0;
            q        <= '0;
            cnt      <= '0;
            div_zero <= 1'b0;
        end else if (start) begin
            rem      <= W'(dividend);
            dsh      <= W'(divisor) << (QW - 1);
            q        <= '0;
            cnt      <= CW'(QW);
            div_zero <= divisor == '0;
        end else if (cnt != '0) begin
            rem <= fit ? rem - dsh : rem;
            dsh <= dsh >> 1;
            q   <= quotient;
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/regular_defuzzification.sv
// regular_defuzzification: centroid defuzzifier accumulating serial memberships and dividing to a crisp value
module regular_defuzzification
    import fuzzy_defuzz_pkg::*;
#(
    parameter int NUM_TERMS = NUM_TERMS_DEF,
    parameter int MU_W      = MU_W_DEF,
    parameter int OUT_W     = OUT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_start,
    input  logic             io_inValid,
    input  logic [MU_W-1:0]  io_inMembership,
    output logic             io_busy,
    output logic             io_outResultValid,
    output logic [OUT_W-1:0] io_outResult
);

    localparam int TW  = $clog2(NUM_TERMS);
    localparam int SMW = sum_mu_width(MU_W, NUM_TERMS);
    localparam int SWW = sum_w_width(MU_W, OUT_W, NUM_TERMS);
    localparam int PW  = MU_W + OUT_W;

    state_t           state;
    logic [SMW-1:0]   sum_mu;
    logic [SMW-1:0]   sum_mu_nxt;
    logic [SWW-1:0]   sum_w;
    logic [SWW-1:0]   sum_w_nxt;
    logic [TW-1:0]    term_idx;
    logic [OUT_W-1:0] center_lut [NUM_TERMS];
    logic [PW-1:0]    prod;
    logic             last;
    logic             div_done;
    logic             div_zero;
    logic [OUT_W-1:0] quotient;

    for (genvar k = 0; k < NUM_TERMS; k++) begin : g_lut
        assign center_lut[k] = OUT_W'(center(k, NUM_TERMS, OUT_W));
    end

    assign prod              = PW'(io_inMembership) * PW'(center_lut[term_idx]);
    assign sum_mu_nxt        = sum_mu + SMW'(io_inMembership);
    assign sum_w_nxt         = sum_w + SWW'(prod);
    assign last              = state == ACCUM && io_inValid && term_idx == TW'(NUM_TERMS - 1);
    assign io_busy           = state != IDLE;
    assign io_outResultValid = state == DONE;

    // The divider sees the sums including the final sample, so it starts on the same edge
    fuzzy_restoring_divider #(
        .DW(SWW),
        .VW(SMW),
        .QW(OUT_W)
    ) u_div (
        .clk      (clock),
        .rst      (reset),
        .start    (last),
        .dividend (sum_w_nxt),
        .divisor  (sum_mu_nxt),
        .done     (div_done),
        .div_zero (div_zero),
        .quotient (quotient)
    );

    // Sequence IDLE -> ACCUM -> DIVIDE -> DONE, accumulating samples and latching the result
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            sum_mu       <= '0;
            sum_w        <= '0;
            term_idx     <= '0;
            io_outResult <= '0;
        end else begin
            case (state)
                IDLE: if (io_start) begin
                    state    <= ACCUM;
                    sum_mu   <= '0;
                    sum_w    <= '0;
                    term_idx <= '0;
                end
                ACCUM: if (io_inValid) begin
                    sum_mu   <= sum_mu_nxt;
                    sum_w    <= sum_w_nxt;
                    term_idx <= term_idx + TW'(1);
                    if (last) state <= DIVIDE;
                end
                DIVIDE: if (div_done) begin
                    state        <= DONE;
                    io_outResult <= div_zero ? '0 : quotient;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regular_defuzzification.sv
// tb_regular_defuzzification: directed checks of centroid results, latency, gaps and robustness
module tb_regular_defuzzification;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       io_start = 1'b0;
    logic       io_inValid = 1'b0;
    logic [9:0] io_inMembership = '0;
    logic       io_busy;
    logic       io_outResultValid;
    logic [9:0] io_outResult;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc;
    int         total;
    logic [9:0] mu [8];

    always #5 clk = ~clk;

    regular_defuzzification dut (
        .clock             (clk),
        .reset             (reset),
        .io_start          (io_start),
        .io_inValid        (io_inValid),
        .io_inMembership   (io_inMembership),
        .io_busy           (io_busy),
        .io_outResultValid (io_outResultValid),
        .io_outResult      (io_outResult)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input int gap, input bit pulse, input int exp);
        io_start = 1'b1;
        step();
        io_start = 1'b0;
        total = 1;
        chk({tag, "_busy"}, 32'(io_busy), 1);
        for (int k = 0; k < 8; k++) begin
            io_inValid = 1'b1;
            io_inMembership = mu[k];
            step();
            total++;
            io_inValid = 1'b0;
            io_inMembership = '0;
            if (k < 7) repeat (gap) begin
                step();
                total++;
            end
        end
        cyc = 1;
        if (pulse) begin
            io_start = 1'b1;
            step();
            cyc++;
            total++;
            io_start = 1'b0;
        end
        while (!io_outResultValid && cyc < 40) begin
            step();
            cyc++;
            total++;
        end
        chk({tag, "_lat"}, 32'(cyc), 11);
        if (gap == 0) chk({tag, "_total"}, 32'(total), 19);
        chk({tag, "_result"}, 32'(io_outResult), 32'(exp));
        step();
        chk({tag, "_valid_drop"}, 32'(io_outResultValid), 0);
        chk({tag, "_busy_drop"}, 32'(io_busy), 0);
        chk({tag, "_hold"}, 32'(io_outResult), 32'(exp));
    endtask

    initial begin
        io_inValid = 1'b1;
        io_inMembership = 10'd777;
        repeat (3) step();
        reset = 1'b0;
        chk("rst_busy", 32'(io_busy), 0);
        chk("rst_valid", 32'(io_outResultValid), 0);
        chk("rst_result", 32'(io_outResult), 0);
        repeat (2) step();
        chk("idle_ignores_valid", 32'(io_busy), 0);
        io_inValid = 1'b0;
        io_inMembership = '0;

        mu = '{10'd0, 10'd0, 10'd0, 10'd1023, 10'd0, 10'd0, 10'd0, 10'd0};
        run("single", 0, 1'b0, 438);
        mu = '{10'd500, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd500};
        run("extremes", 0, 1'b0, 511);
        mu = '{10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd1023};
        run("all_max", 0, 1'b0, 511);
        mu = '{10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0};
        run("all_zero", 0, 1'b0, 0);
        mu = '{10'd0, 10'd0, 10'd0, 10'd1023, 10'd0, 10'd0, 10'd0, 10'd0};
        run("gapped", 3, 1'b0, 438);
        mu = '{10'd0, 10'd0, 10'd300, 10'd0, 10'd0, 10'd300, 10'd0, 10'd0};
        run("mid_pair", 0, 1'b0, 511);
        mu = '{10'd0, 10'd0, 10'd0, 10'd1023, 10'd0, 10'd0, 10'd0, 10'd0};
        run("start_in_divide", 0, 1'b1, 438);

        io_start = 1'b1;
        step();
        io_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            io_inValid = 1'b1;
            io_inMembership = 10'd1023;
            step();
        end
        io_inValid = 1'b0;
        io_inMembership = '0;
        chk("pre_reset_busy", 32'(io_busy), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_reset_busy", 32'(io_busy), 0);
        chk("mid_reset_valid", 32'(io_outResultValid), 0);
        chk("mid_reset_result", 32'(io_outResult), 0);
        step();
        chk("mid_reset_idle", 32'(io_busy), 0);

        mu = '{10'd500, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd500};
        run("after_reset", 0, 1'b0, 511);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
